fp_mult_arbiter: RTL and testbench

FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

---
 rtl/fp_arb_pkg.sv | 32 +++
 rtl/fp_mult_arbiter_rr_arbiter.sv | 34 +++
 rtl/fp_mult_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fp_mult_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared definitions for the floating-point multiplier arbiter.
// Holds the default operand geometry, the operand width helper, the tag
// record that travels alongside each multiply, and the fixed requester
// indices of the three clients (angle combination, angle normalisation,
// term accumulation).
package fp_arb_pkg;

  localparam int DEF_EXP_LEN      = 8;
  localparam int DEF_MANTISSA_LEN = 23;
  localparam int DEF_NUM_REQ      = 3;

  // Sign bit plus exponent plus mantissa.
  function automatic int fp_width(input int exp_len, input int mantissa_len);
    return exp_len + mantissa_len + 1;
  endfunction

  localparam int FP_W  = fp_width(DEF_EXP_LEN, DEF_MANTISSA_LEN);
  localparam int IDX_W = (DEF_NUM_REQ > 1) ? $clog2(DEF_NUM_REQ) : 1;

  localparam logic [IDX_W-1:0] REQ_ANGLE_COMB = IDX_W'(0);
  localparam logic [IDX_W-1:0] REQ_ANGLE_NORM = IDX_W'(1);
  localparam logic [IDX_W-1:0] REQ_TERM_ACC   = IDX_W'(2);

  // One slot of the tag pipeline: whether a multiply occupies the slot and
  // which requester its result belongs to.  The index field is sized for the
  // default requester count, so NUM_REQ must not exceed 2**IDX_W.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin grant selection.
// Ports:
//   req   - per-requester request vector (already qualified by enable)
//   ptr   - index of the most recent grant
//   grant - one-hot grant, empty when nothing is requested
// The search starts one past ptr and wraps from N-1 back to 0, so the
// requester granted last has the lowest priority next time.
module rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  // Walk the requesters in priority order and take the first one asking.
  always_comb begin
    int unsigned pos;
    logic        found;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined floating-point multiplier between several requesters.
// Ports:
//   clk, reset                  - rising-edge clock, async active-low reset
//   enable                      - allows new grants (in-flight work still drains)
//   req_valid/req_op_a/req_op_b - per-requester operand pairs, flattened
//   req_ready                   - one-hot grant; transfer on valid && ready
//   mult_in_valid/mult_op_a/b   - registered operands to the shared multiplier
//   mult_out_valid/mult_result  - multiplier output, MULT_LATENCY cycles later
//   resp_valid/resp_result      - one-hot result strobe and broadcast result
//   busy                        - any multiply in flight
//   tag_error                   - sticky: multiplier output disagreed with tags
//   grant_count                 - per-requester saturating transfer counters,
//                                 present only when FP_ARB_STATS_EN is defined
module fp_mult_arbiter
  import fp_arb_pkg::*;
#(
  parameter int EXP_LEN      = DEF_EXP_LEN,
  parameter int MANTISSA_LEN = DEF_MANTISSA_LEN,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int MULT_LATENCY = 4
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                enable,
  input  logic [NUM_REQ-1:0]                                  req_valid,
  input  logic [NUM_REQ*fp_width(EXP_LEN, MANTISSA_LEN)-1:0]  req_op_a,
  input  logic [NUM_REQ*fp_width(EXP_LEN, MANTISSA_LEN)-1:0]  req_op_b,
  output logic [NUM_REQ-1:0]                                  req_ready,
  output logic                                                mult_in_valid,
  output logic [fp_width(EXP_LEN, MANTISSA_LEN)-1:0]          mult_op_a,
  output logic [fp_width(EXP_LEN, MANTISSA_LEN)-1:0]          mult_op_b,
  input  logic                                                mult_out_valid,
  input  logic [fp_width(EXP_LEN, MANTISSA_LEN)-1:0]          mult_result,
  output logic [NUM_REQ-1:0]                                  resp_valid,
  output logic [fp_width(EXP_LEN, MANTISSA_LEN)-1:0]          resp_result,
  output logic                                                busy,
  output logic                                                tag_error
`ifdef FP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]                               grant_count
`endif
);

  localparam int W     = fp_width(EXP_LEN, MANTISSA_LEN);
  localparam int DEPTH = 1 + MULT_LATENCY;

  logic [NUM_REQ-1:0] req_live;
  logic [NUM_REQ-1:0] grant;
  logic               transfer;
  logic [IDX_W-1:0]   grant_idx;
  logic [W-1:0]       sel_a;
  logic [W-1:0]       sel_b;

  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               mult_in_valid_q, mult_in_valid_d;
  logic [W-1:0]       mult_op_a_q, mult_op_a_d;
  logic [W-1:0]       mult_op_b_q, mult_op_b_d;
  logic               tag_error_q, tag_error_d;
  tag_t               tag_q [DEPTH];
  tag_t               tag_d [DEPTH];

  tag_t               tag_out;
  logic               resp_fire;

  // Requests count only while enabled and out of reset, which keeps
  // req_ready low during reset even though it is combinational.
  assign req_live = reset ? (req_valid & {NUM_REQ{enable}}) : '0;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req   (req_live),
    .ptr   (last_grant_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  // Encode the one-hot grant and pick the winning operand pair.
  always_comb begin
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_a     = req_op_a[i*W +: W];
        sel_b     = req_op_b[i*W +: W];
      end
    end
  end

  // Next-state logic.  The tag pipeline is one stage longer than the
  // multiplier so that its last stage lines up with mult_out_valid: one
  // cycle for the operand register plus MULT_LATENCY inside the multiplier.
  // Operands hold their last value when idle to avoid needless toggling.
  always_comb begin
    last_grant_d    = transfer ? grant_idx : last_grant_q;
    mult_in_valid_d = transfer;
    mult_op_a_d     = transfer ? sel_a : mult_op_a_q;
    mult_op_b_d     = transfer ? sel_b : mult_op_b_q;
    for (int s = 0; s < DEPTH; s++) begin
      tag_d[s] = tag_q[s];
    end
    tag_d[0].valid = transfer;
    tag_d[0].idx   = grant_idx;
    for (int s = 1; s < DEPTH; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    tag_error_d = tag_error_q | (mult_out_valid != tag_out.valid);
  end

  // State registers; reset also discards every in-flight tag so nothing
  // issued before reset can produce a response afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      mult_in_valid_q <= 1'b0;
      mult_op_a_q     <= '0;
      mult_op_b_q     <= '0;
      tag_error_q     <= 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      last_grant_q    <= last_grant_d;
      mult_in_valid_q <= mult_in_valid_d;
      mult_op_a_q     <= mult_op_a_d;
      mult_op_b_q     <= mult_op_b_d;
      tag_error_q     <= tag_error_d;
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign tag_out   = tag_q[DEPTH-1];
  assign resp_fire = tag_out.valid && mult_out_valid;

  // Route the multiplier result back to the requester named by the tag; a
  // mismatch between tag and multiplier valid yields no response.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = resp_fire && (tag_out.idx == IDX_W'(i));
    end
    resp_result = resp_fire ? mult_result : '0;
  end

  // The operand stage is covered by tag stage 0, so busy reduces to any
  // occupied tag slot.
  always_comb begin
    busy = mult_in_valid_q;
    for (int s = 0; s < DEPTH; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

  assign mult_in_valid = mult_in_valid_q;
  assign mult_op_a     = mult_op_a_q;
  assign mult_op_b     = mult_op_b_q;
  assign tag_error     = tag_error_q;

`ifdef FP_ARB_STATS_EN
  logic [15:0] count_q [NUM_REQ];
  logic [15:0] count_d [NUM_REQ];

  // Transfer counters stick at 0xFFFF instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      count_d[i] = count_q[i];
      if (grant[i] && (count_q[i] != 16'hFFFF)) begin
        count_d[i] = count_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count[i*16 +: 16] = count_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: drives directed vectors, emulates the shared
// multiplier with a fixed-latency pipeline, and compares every cycle
// against a queue-based model of the arbitration and response timing.
// The grant counter scenario is built only when FP_ARB_STATS_EN is defined.
module tb_fp_mult_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_op_a;
  logic [N*W-1:0] req_op_b;
  logic [N-1:0]   req_ready;
  logic           mult_in_valid;
  logic [W-1:0]   mult_op_a;
  logic [W-1:0]   mult_op_b;
  logic           mult_out_valid;
  logic [W-1:0]   mult_result;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           busy;
  logic           tag_error;
`ifdef FP_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  fp_mult_arbiter #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_REQ(N), .MULT_LATENCY(ML)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_op_a       (req_op_a),
    .req_op_b       (req_op_b),
    .req_ready      (req_ready),
    .mult_in_valid  (mult_in_valid),
    .mult_op_a      (mult_op_a),
    .mult_op_b      (mult_op_b),
    .mult_out_valid (mult_out_valid),
    .mult_result    (mult_result),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .busy           (busy),
    .tag_error      (tag_error)
`ifdef FP_ARB_STATS_EN
    ,
    .grant_count    (grant_count)
`endif
  );

  always #5 clk = ~clk;

  // Single-precision multiply for normal operands, truncating the mantissa.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  int cyc = 0;
  int kill_cycle = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shared multiplier: fixed latency, resettable, and able to
  // drop its output valid on one chosen cycle.
  logic         pv [ML];
  logic [W-1:0] pr [ML];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ML; k++) begin
        pv[k] <= 1'b0;
        pr[k] <= '0;
      end
    end else begin
      pv[0] <= mult_in_valid;
      pr[0] <= fmul(mult_op_a, mult_op_b);
      for (int k = 1; k < ML; k++) begin
        pv[k] <= pv[k-1];
        pr[k] <= pr[k-1];
      end
    end
  end

  assign mult_out_valid = pv[ML-1] && (cyc != kill_cycle);
  assign mult_result    = pr[ML-1];

  int errors = 0;
  int checks = 0;

  task automatic expect_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Hand-computed expectations posted by the stimulus for one cycle.
  logic         lit_ready_en = 1'b0;
  logic [N-1:0] lit_ready    = '0;
  logic         lit_rv_en    = 1'b0;
  logic [N-1:0] lit_rv       = '0;
  logic         lit_res_en   = 1'b0;
  logic [W-1:0] lit_res      = '0;
  logic         lit_terr_en  = 1'b0;
  logic         lit_terr     = 1'b0;
  logic         lit_busy_en  = 1'b0;
  logic         lit_busy     = 1'b0;
  logic         lit_gc_en    = 1'b0;

  typedef struct {
    int           idx;
    logic [W-1:0] res;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           ptr = N - 1;
  logic         exp_terr = 1'b0;
  logic         prev_xfer = 1'b0;
  logic [W-1:0] prev_a = '0;

  // Model and compare process, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_res;
    logic [N-1:0] g;
    logic         had;
    logic         terr_next;
    int           gi;
    int           i;
    exp_rv    = '0;
    exp_res   = '0;
    g         = '0;
    gi        = 0;
    terr_next = 1'b0;
    if (!reset) begin
      expect_output("rst_req_ready", 64'(req_ready), 64'd0);
      expect_output("rst_resp_valid", 64'(resp_valid), 64'd0);
      expect_output("rst_resp_result", 64'(resp_result), 64'd0);
      expect_output("rst_mult_in_valid", 64'(mult_in_valid), 64'd0);
      expect_output("rst_mult_op_a", 64'(mult_op_a), 64'd0);
      expect_output("rst_busy", 64'(busy), 64'd0);
      expect_output("rst_tag_error", 64'(tag_error), 64'd0);
      q.delete();
      ptr       = N - 1;
      exp_terr  = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      had = (q.size() > 0);
      if (q.size() > 0 && q[0].due == cyc) begin
        if (cyc != kill_cycle) begin
          exp_rv  = N'(1) << q[0].idx;
          exp_res = q[0].res;
        end else begin
          terr_next = 1'b1;
        end
        void'(q.pop_front());
      end
      expect_output("resp_valid", 64'(resp_valid), 64'(exp_rv));
      expect_output("resp_result", 64'(resp_result), 64'(exp_res));
      expect_output("busy", 64'(busy), 64'(had));
      expect_output("tag_error", 64'(tag_error), 64'(exp_terr));
      expect_output("mult_in_valid", 64'(mult_in_valid), 64'(prev_xfer));
      if (prev_xfer) expect_output("mult_op_a", 64'(mult_op_a), 64'(prev_a));

      for (int k = 1; k <= N; k++) begin
        i = (ptr + k) % N;
        if (enable && req_valid[i] && g == '0) begin
          g  = N'(1) << i;
          gi = i;
        end
      end
      expect_output("req_ready", 64'(req_ready), 64'(g));
      if (g != '0) begin
        q.push_back('{idx: gi, res: fmul(req_op_a[gi*W +: W], req_op_b[gi*W +: W]), due: cyc + 1 + ML});
        ptr    = gi;
        prev_a = req_op_a[gi*W +: W];
      end
      prev_xfer = (g != '0);
      if (terr_next) exp_terr = 1'b1;

      if (lit_ready_en) expect_output("lit_req_ready", 64'(req_ready), 64'(lit_ready));
      if (lit_rv_en)    expect_output("lit_resp_valid", 64'(resp_valid), 64'(lit_rv));
      if (lit_res_en)   expect_output("lit_resp_result", 64'(resp_result), 64'(lit_res));
      if (lit_terr_en)  expect_output("lit_tag_error", 64'(tag_error), 64'(lit_terr));
      if (lit_busy_en)  expect_output("lit_busy", 64'(busy), 64'(lit_busy));
`ifdef FP_ARB_STATS_EN
      if (lit_gc_en) begin
        expect_output("grant_count0", 64'(grant_count[15:0]), 64'h0);
        expect_output("grant_count1", 64'(grant_count[31:16]), 64'h0);
        expect_output("grant_count2", 64'(grant_count[47:32]), 64'hFFFF);
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_ready_en = 1'b0;
    lit_rv_en    = 1'b0;
    lit_res_en   = 1'b0;
    lit_terr_en  = 1'b0;
    lit_busy_en  = 1'b0;
    lit_gc_en    = 1'b0;
  endtask

  task automatic apply_stimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op_a[idx*W +: W] = a;
    req_op_b[idx*W +: W] = b;
  endtask

  int k0;

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    req_op_a  = '0;
    req_op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    $display("[TB] round-robin with all requesters valid");
    apply_stimulus(0, 32'h40000000, 32'h3FC00000);
    apply_stimulus(1, 32'h40400000, 32'h3FC00000);
    apply_stimulus(2, 32'h40800000, 32'h3FC00000);
    req_valid = 3'b111;
    for (int j = 0; j < 16; j++) begin
      if (j == 9) req_valid = '0;
      if (j < 9) begin
        lit_ready_en = 1'b1;
        lit_ready    = 3'b001 << (j % 3);
      end
      if (j >= 5 && j < 14) begin
        lit_rv_en = 1'b1;
        lit_rv    = 3'b001 << ((j - 5) % 3);
      end
      if (j == 5) begin
        lit_res_en = 1'b1;
        lit_res    = 32'h40400000;
      end
      if (j == 15) begin
        lit_busy_en = 1'b1;
        lit_busy    = 1'b0;
      end
      step();
    end

    $display("[TB] single request from requester 0");
    apply_stimulus(0, 32'h40000000, 32'h40400000);
    req_valid = 3'b001;
    for (int j = 0; j < 8; j++) begin
      if (j == 1) req_valid = '0;
      if (j == 0) begin
        lit_ready_en = 1'b1;
        lit_ready    = 3'b001;
      end
      if (j == 4 || j == 5) begin
        lit_rv_en = 1'b1;
        lit_rv    = (j == 5) ? 3'b001 : 3'b000;
      end
      if (j == 5) begin
        lit_res_en = 1'b1;
        lit_res    = 32'h40C00000;
      end
      if (j == 6) begin
        lit_busy_en = 1'b1;
        lit_busy    = 1'b0;
      end
      step();
    end

    $display("[TB] enable gating");
    apply_stimulus(1, 32'h3F800000, 32'h40A00000);
    enable    = 1'b0;
    req_valid = 3'b010;
    for (int j = 0; j < 11; j++) begin
      if (j == 3) enable = 1'b1;
      if (j == 4) req_valid = '0;
      if (j <= 3) begin
        lit_ready_en = 1'b1;
        lit_ready    = (j == 3) ? 3'b010 : 3'b000;
      end
      step();
    end

    $display("[TB] dropped multiplier output");
    apply_stimulus(0, 32'h40000000, 32'h40000000);
    req_valid  = 3'b001;
    k0         = cyc;
    kill_cycle = k0 + 1 + ML;
    for (int j = 0; j < 12; j++) begin
      if (j == 1) req_valid = '0;
      if (j == 0) begin
        lit_ready_en = 1'b1;
        lit_ready    = 3'b001;
      end
      if (j == 5) begin
        lit_rv_en = 1'b1;
        lit_rv    = 3'b000;
      end
      if (j == 5 || j == 6 || j == 11) begin
        lit_terr_en = 1'b1;
        lit_terr    = (j != 5);
      end
      step();
    end

    $display("[TB] reset with operations in flight");
    req_valid = 3'b111;
    for (int j = 0; j < 16; j++) begin
      if (j == 3) req_valid = '0;
      if (j == 4) reset = 1'b0;
      if (j == 6) reset = 1'b1;
      if (j >= 6 && j < 12) begin
        lit_rv_en   = 1'b1;
        lit_rv      = 3'b000;
        lit_busy_en = 1'b1;
        lit_busy    = 1'b0;
        lit_terr_en = 1'b1;
        lit_terr    = 1'b0;
      end
      if (j == 12) begin
        req_valid    = 3'b111;
        lit_ready_en = 1'b1;
        lit_ready    = 3'b001;
      end
      if (j == 13) req_valid = '0;
      step();
    end
    repeat (6) step();

`ifdef FP_ARB_STATS_EN
    $display("[TB] grant counter saturation");
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    apply_stimulus(2, 32'h3F800000, 32'h3F800000);
    req_valid = 3'b100;
    for (int j = 0; j < 70000; j++) step();
    req_valid = '0;
    step();
    lit_gc_en = 1'b1;
    step();
    repeat (6) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
